alu_seq: RTL



---
 rtl/alu_seq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, issued through a start/ready/valid handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] c,
  output logic             is_zero,
  output logic             is_negative,
  output logic             carry,
  output logic             div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W2  = 2 * WIDTH;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_CMP  = 5'd8;
  localparam logic [4:0] OP_PASS = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd12;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_SAR  = 5'd14;
  localparam logic [4:0] OP_MULL = 5'd17;
  localparam logic [4:0] OP_MULH = 5'd18;
  localparam logic [4:0] OP_DIVU = 5'd19;
  localparam logic [4:0] OP_REMU = 5'd20;
  localparam logic [4:0] OP_DIVS = 5'd21;
  localparam logic [4:0] OP_REMS = 5'd22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic f_mul(input logic [4:0] o);
    return (o == OP_MULL) || (o == OP_MULH);
  endfunction

  function automatic logic f_div(input logic [4:0] o);
    return (o >= OP_DIVU) && (o <= OP_REMS);
  endfunction

  function automatic logic f_sdiv(input logic [4:0] o);
    return (o == OP_DIVS) || (o == OP_REMS);
  endfunction

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic             dbz_q, dbz_d, valid_q, valid_d, ready_q, ready_d;

  logic [4:0]       op_in;
  logic             unused_op;
  logic             in_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [WIDTH-1:0] acc_lo, acc_hi;
  logic [SHW-1:0]   sh;
  logic             b_zero, q_neg;
  logic [WIDTH-1:0] res;
  logic             res_cy, res_dz;
  logic [WIDTH:0]   sum;

  assign op_in     = op[4:0];
  assign unused_op = ^op[7:5];
  assign in_sgn    = f_sdiv(op_in);
  assign a_mag     = (in_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (in_sgn && b[WIDTH-1]) ? -b : b;

  // One radix-2 step: multiplier sits in the low half, remainder/quotient share acc
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign div_diff = acc_q[W2-1:WIDTH-1] - {1'b0, dvs_q};

  assign acc_lo = acc_q[WIDTH-1:0];
  assign acc_hi = acc_q[W2-1:WIDTH];
  assign sh     = b_q[SHW-1:0];
  assign b_zero = (b_q == '0);
  assign q_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  // Final result and flags, evaluated in DONE from latched operands / accumulator
  always_comb begin
    res    = '0;
    res_cy = 1'b0;
    res_dz = 1'b0;
    sum    = '0;
    case (op_q)
      OP_ADD: begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        res    = sum[WIDTH-1:0];
        res_cy = sum[WIDTH];
      end
      OP_SUB: begin
        sum    = {1'b0, a_q} - {1'b0, b_q};
        res    = sum[WIDTH-1:0];
        res_cy = sum[WIDTH];
      end
      OP_OR:   res = a_q | b_q;
      OP_AND:  res = a_q & b_q;
      OP_NOT:  res = ~a_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_CMP: begin
        if ($signed(a_q) < $signed(b_q)) res = '1;
        else if (a_q == b_q)             res = '0;
        else                             res = WIDTH'(1);
      end
      OP_PASS: res = a_q;
      OP_SHL:  res = a_q << sh;
      OP_SHR:  res = a_q >> sh;
      OP_SAR:  res = $signed(a_q) >>> sh;
      OP_MULL: res = acc_lo;
      OP_MULH: res = acc_hi;
      OP_DIVU: begin
        res    = b_zero ? '1 : acc_lo;
        res_dz = b_zero;
      end
      OP_REMU: begin
        res    = b_zero ? a_q : acc_hi;
        res_dz = b_zero;
      end
      OP_DIVS: begin
        res    = b_zero ? '1 : (q_neg ? -acc_lo : acc_lo);
        res_dz = b_zero;
      end
      OP_REMS: begin
        res    = b_zero ? a_q : (a_q[WIDTH-1] ? -acc_hi : acc_hi);
        res_dz = b_zero;
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    valid_d = 1'b0;
    c_d     = c_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op_in;
          a_d   = a;
          b_d   = b;
          cnt_d = SHW'(WIDTH - 1);
          if (f_mul(op_in)) begin
            acc_d   = {{WIDTH{1'b0}}, b};
            dvs_d   = a;
            state_d = S_ITER;
          end else if (f_div(op_in)) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            dvs_d   = b_mag;
            state_d = S_ITER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ITER: begin
        if (f_mul(op_q))          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                      acc_d = {acc_q[W2-2:0], 1'b0};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        c_d     = res;
        zero_d  = (res == '0);
        neg_d   = res[WIDTH-1];
        carry_d = res_cy;
        dbz_d   = res_dz;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      c_q     <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = ready_q;
  assign valid       = valid_q;
  assign c           = c_q;
  assign is_zero     = zero_q;
  assign is_negative = neg_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;

endmodule
